debug_console: RTL and testbench

Board-level debug front end for the 16-bit processor: replaces the fixed 8-way probe mux and free-wired hex inputs with a parametrised console. It generates the processor clock-enable, either single-stepped from a filtered key strobe or free-running at a divided rate. It also captures one of `CHANNELS` probe words for the hex decoders, selected manually or by auto-rotation, with a freeze option. It sits between the key filter / switches and the processor plus `Decoder_hex` array.

---
 rtl/debug_pkg.sv | 13 +
 rtl/step_gen.sv | 65 ++++++
 rtl/debug_console.sv | 78 +++++++
 tb/tb_debug_console.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared types and default timing constants for the debug console.
package debug_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      RUN  = 2'd2
   } step_state_t;

   localparam int unsigned DefRotateCycles = 50_000_000;
   localparam int unsigned DefRunDiv       = 5_000_000;

endpackage

// File: rtl/step_gen.sv
// Processor clock-enable generator: single-step or divided free-run, plus pulse counter.
module step_gen
   import debug_pkg::*;
#(
   parameter int unsigned RunDiv = DefRunDiv
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        step_req_i,
   input  logic        run_mode_i,
   output logic        proc_enable_o,
   output logic [15:0] step_count_o
);

   localparam int unsigned DW = $clog2(RunDiv);

   step_state_t   state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic          proc_en_q, proc_en_d;
   logic [15:0]   step_cnt_q, step_cnt_d;

   always_comb begin
      state_d = state_q;
      div_d   = '0;
      unique case (state_q)
         IDLE: begin
            if (run_mode_i) begin
               state_d = RUN;
            end else if (step_req_i) begin
               state_d = STEP;
            end
         end
         STEP: state_d = IDLE;
         RUN: begin
            if (!run_mode_i) begin
               state_d = IDLE;
            end else if (div_q != DW'(RunDiv - 1)) begin
               div_d = div_q + DW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // Pulse is registered so it lines up with the state/count it belongs to.
      proc_en_d  = (state_d == STEP) || ((state_d == RUN) && (div_d == DW'(RunDiv - 1)));
      step_cnt_d = step_cnt_q + 16'(proc_en_q);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         div_q      <= '0;
         proc_en_q  <= 1'b0;
         step_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         proc_en_q  <= proc_en_d;
         step_cnt_q <= step_cnt_d;
      end
   end

   assign proc_enable_o = proc_en_q;
   assign step_count_o  = step_cnt_q;

endmodule

// File: rtl/debug_console.sv
// Debug front end: processor step/run enable plus probe channel selection and hex capture.
module debug_console
   import debug_pkg::*;
#(
   parameter int unsigned WIDTH         = 16,
   parameter int unsigned CHANNELS      = 8,
   parameter int unsigned ROTATE_CYCLES = DefRotateCycles,
   parameter int unsigned RUN_DIV       = DefRunDiv,
   parameter int unsigned CW            = $clog2(CHANNELS)
) (
   input  logic                               Clock,
   input  logic                               Reset_n,
   input  logic                               StepReq,
   input  logic                               RunMode,
   input  logic                               AutoRotate,
   input  logic [CW-1:0]                      ChanSel,
   input  logic                               Freeze,
   input  logic [CHANNELS-1:0][WIDTH-1:0]     Probes,
   output logic                               ProcEnable,
   output logic [CW-1:0]                      ShownChan,
   output logic [WIDTH/4-1:0][3:0]            Digits,
   output logic [15:0]                        StepCount
);

   localparam int unsigned RW = (ROTATE_CYCLES > 1) ? $clog2(ROTATE_CYCLES) : 1;

   step_gen #(
      .RunDiv (RUN_DIV)
   ) u_step_gen (
      .clk_i         (Clock),
      .rst_ni        (Reset_n),
      .step_req_i    (StepReq),
      .run_mode_i    (RunMode),
      .proc_enable_o (ProcEnable),
      .step_count_o  (StepCount)
   );

   // The channel index doubles as the displayed channel: both update and freeze together.
   logic [CW-1:0]            chan_q, chan_d;
   logic [RW-1:0]            rot_q, rot_d;
   logic [WIDTH/4-1:0][3:0]  digits_q, digits_d;

   always_comb begin
      chan_d   = chan_q;
      rot_d    = rot_q;
      digits_d = digits_q;
      if (!Freeze) begin
         if (AutoRotate) begin
            if (rot_q == RW'(ROTATE_CYCLES - 1)) begin
               rot_d  = '0;
               chan_d = (chan_q == CW'(CHANNELS - 1)) ? '0 : chan_q + CW'(1);
            end else begin
               rot_d = rot_q + RW'(1);
            end
         end else begin
            rot_d  = '0;
            chan_d = (32'(ChanSel) < CHANNELS) ? ChanSel : CW'(CHANNELS - 1);
         end
         digits_d = Probes[chan_d];
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         chan_q   <= '0;
         rot_q    <= '0;
         digits_q <= '0;
      end else begin
         chan_q   <= chan_d;
         rot_q    <= rot_d;
         digits_q <= digits_d;
      end
   end

   assign ShownChan = chan_q;
   assign Digits    = digits_q;

endmodule

// File: tb/tb_debug_console.sv
// Directed bench for debug_console with RUN_DIV = 4, ROTATE_CYCLES = 3, CHANNELS = 5.
module tb_debug_console;

   localparam int unsigned W  = 16;
   localparam int unsigned CH = 5;
   localparam int unsigned CW = 3;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  step_req;
   logic                  run_mode;
   logic                  auto_rot;
   logic [CW-1:0]         chan_sel;
   logic                  freeze;
   logic [CH-1:0][W-1:0]  probes;
   logic                  proc_en;
   logic [CW-1:0]         shown;
   logic [W/4-1:0][3:0]   digits;
   logic [15:0]           step_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   debug_console #(
      .WIDTH         (W),
      .CHANNELS      (CH),
      .ROTATE_CYCLES (3),
      .RUN_DIV       (4),
      .CW            (CW)
   ) dut (
      .Clock      (clk),
      .Reset_n    (rst_n),
      .StepReq    (step_req),
      .RunMode    (run_mode),
      .AutoRotate (auto_rot),
      .ChanSel    (chan_sel),
      .Freeze     (freeze),
      .Probes     (probes),
      .ProcEnable (proc_en),
      .ShownChan  (shown),
      .Digits     (digits),
      .StepCount  (step_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      step_req = 1'b0;
      run_mode = 1'b0;
      auto_rot = 1'b0;
      chan_sel = '0;
      freeze   = 1'b0;
      for (int i = 0; i < CH; i++) probes[i] = 16'(16'h1111 * i);
      probes[0] = 16'h5A5A;  // nonzero so the reset check on Digits is meaningful
      tick();
      tick();
      check("rst_pe",     32'(proc_en),  0);
      check("rst_cnt",    32'(step_cnt), 0);
      check("rst_chan",   32'(shown),    0);
      check("rst_digits", 32'(digits),   0);
      probes[0] = 16'h0000;

      // Single step
      rst_n    = 1'b1;
      step_req = 1'b1;
      tick();
      check("step_pe_hi",  32'(proc_en),  1);
      check("step_cnt_0",  32'(step_cnt), 0);
      step_req = 1'b0;
      tick();
      check("step_pe_lo",  32'(proc_en),  0);
      check("step_cnt_1",  32'(step_cnt), 1);

      // Strobe held for two cycles gives a single pulse
      step_req = 1'b1;
      tick();
      check("dbl_pe_1", 32'(proc_en), 1);
      tick();
      check("dbl_pe_2", 32'(proc_en), 0);
      step_req = 1'b0;
      tick();
      check("dbl_pe_3",  32'(proc_en),  0);
      check("dbl_cnt",   32'(step_cnt), 2);

      // Free run: pulse every 4th cycle, StepReq ignored
      run_mode = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         if (k == 5) step_req = 1'b1;
         if (k == 7) step_req = 1'b0;
         tick();
         check($sformatf("run_pe_%0d", k), 32'(proc_en), (k % 4 == 0) ? 1 : 0);
      end
      check("run_cnt", 32'(step_cnt), 4);
      run_mode = 1'b0;
      tick();
      check("run_exit_pe",  32'(proc_en),  0);
      check("run_exit_cnt", 32'(step_cnt), 5);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("idle_pe", 32'(proc_en), 0);
      end
      step_req = 1'b1;
      tick();
      check("post_run_pe", 32'(proc_en), 1);
      step_req = 1'b0;
      tick();
      check("post_run_cnt", 32'(step_cnt), 6);

      // Auto-rotate: advance every 3 cycles, wrap 4 -> 0
      auto_rot = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         tick();
         check($sformatf("rot_chan_%0d", k), 32'(shown), (k / 3) % 5);
         check($sformatf("rot_dig_%0d", k), 32'(digits), 32'(16'(16'h1111 * ((k / 3) % 5))));
      end

      // Manual select with clamp, then freeze
      auto_rot = 1'b0;
      chan_sel = 3'd7;
      tick();
      check("clamp_chan", 32'(shown),  4);
      check("clamp_dig",  32'(digits), 32'h4444);
      chan_sel = 3'd2;
      tick();
      check("man_chan", 32'(shown),  2);
      check("man_dig",  32'(digits), 32'h2222);
      freeze    = 1'b1;
      probes[2] = 16'hABCD;
      chan_sel  = 3'd3;
      tick();
      check("frz_chan_1", 32'(shown),  2);
      check("frz_dig_1",  32'(digits), 32'h2222);
      tick();
      check("frz_dig_2",  32'(digits), 32'h2222);
      freeze = 1'b0;
      tick();
      check("unfrz_chan", 32'(shown),  3);
      check("unfrz_dig",  32'(digits), 32'h3333);
      chan_sel = 3'd2;
      tick();
      check("probe_upd", 32'(digits), 32'hABCD);

      // StepCount wrap: preload near the top, then let one pulse land
      step_req = 1'b1;
      tick();
      check("wrap_pe", 32'(proc_en), 1);
      force dut.u_step_gen.step_cnt_q = 16'hFFFF;
      #1;
      release dut.u_step_gen.step_cnt_q;
      step_req = 1'b0;
      check("wrap_pre", 32'(step_cnt), 32'hFFFF);
      tick();
      check("wrap_cnt", 32'(step_cnt), 0);

      // Reset in the middle of RUN, on the edge that would have pulsed
      auto_rot = 1'b1;
      run_mode = 1'b1;
      for (int k = 0; k < 7; k++) tick();
      check("mid_run_cnt",  32'(step_cnt), 1);
      check("mid_run_chan", 32'(shown),    4);
      rst_n = 1'b0;
      tick();
      check("rrst_pe",     32'(proc_en),  0);
      check("rrst_cnt",    32'(step_cnt), 0);
      check("rrst_chan",   32'(shown),    0);
      check("rrst_digits", 32'(digits),   0);
      rst_n    = 1'b1;
      run_mode = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
